serial_deserializer: RTL and testbench

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

---
 rtl/serial_deserializer.sv | 106 ++++++++++
 tb/tb_serial_deserializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// Serial-to-parallel word assembler with start framing,
// selectable bit order and a one-word output holding register.
module serial_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             ser_start,
  input  logic             ser_dir,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic             dir_q;
  logic [WIDTH-1:0] par_out_q;
  logic             par_valid_q;
  logic             frame_err_q;
  logic             overrun_q;

  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] first_d;
  logic             last_beat;
  logic             can_load;

  // Next shift-register value for a data beat, and the seed for a start beat.
  always_comb begin
    shreg_d = shreg_q;
    first_d = '0;
    if (dir_q) begin
      shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
    end else begin
      shreg_d = {shreg_q[WIDTH-2:0], ser_in};
    end
    if (ser_dir) begin
      first_d[WIDTH-1] = ser_in;
    end else begin
      first_d[0] = ser_in;
    end
  end

  assign last_beat = (cnt_q == CW'(WIDTH - 1));
  assign can_load  = !par_valid_q || par_ready;

  // Framing FSM, shift register and output holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      dir_q       <= 1'b0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (par_valid_q && par_ready) begin
        par_valid_q <= 1'b0;
      end
      if (ser_valid) begin
        if (ser_start) begin
          frame_err_q <= (state_q == SHIFT);
          shreg_q     <= first_d;
          dir_q       <= ser_dir;
          cnt_q       <= CW'(1);
          state_q     <= SHIFT;
        end else if (state_q == SHIFT) begin
          shreg_q <= shreg_d;
          if (last_beat) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            if (can_load) begin
              par_out_q   <= shreg_d;
              par_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end
    end
  end

  assign par_out   = par_out_q;
  assign par_valid = par_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer with a word-level
// reference model checked every cycle plus literal expectations.
module tb_serial_deserializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ser_in = 1'b0;
  logic         ser_valid = 1'b0;
  logic         ser_start = 1'b0;
  logic         ser_dir = 1'b0;
  logic [W-1:0] par_out;
  logic         par_valid;
  logic         par_ready = 1'b0;
  logic         frame_err;
  logic         overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ferr = 0;
  int n_vcyc = 0;
  logic [W-1:0] last_word = '0;

  serial_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_start (ser_start),
    .ser_dir   (ser_dir),
    .par_out   (par_out),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Word-level model: collect the bits of a frame in arrival order,
  // then place them by bit order once W bits have arrived.
  logic         m_active = 1'b0;
  logic         m_dir = 1'b0;
  bit           m_bits[$];
  logic [W-1:0] m_out = '0;
  logic         m_valid = 1'b0;
  logic         m_ferr = 1'b0;
  logic         m_ovr = 1'b0;

  always @(posedge clk) begin
    logic         old_valid;
    logic [W-1:0] w;
    if (reset) begin
      m_active = 1'b0;
      m_bits.delete();
      m_out = '0;
      m_valid = 1'b0;
      m_ferr = 1'b0;
      m_ovr = 1'b0;
      m_dir = 1'b0;
    end else begin
      old_valid = m_valid;
      m_ferr = 1'b0;
      if (old_valid && par_ready) m_valid = 1'b0;
      if (ser_valid) begin
        if (ser_start) begin
          if (m_active) m_ferr = 1'b1;
          m_active = 1'b1;
          m_dir = ser_dir;
          m_bits.delete();
          m_bits.push_back(ser_in);
        end else if (m_active) begin
          m_bits.push_back(ser_in);
          if (m_bits.size() == W) begin
            for (int i = 0; i < W; i++) begin
              if (m_dir) w[i] = m_bits[i];
              else w[W-1-i] = m_bits[i];
            end
            m_active = 1'b0;
            m_bits.delete();
            if (!old_valid || par_ready) begin
              m_out = w;
              m_valid = 1'b1;
            end else begin
              m_ovr = 1'b1;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("par_valid", 32'(par_valid), 32'(m_valid));
    check("par_out", 32'(par_out), 32'(m_out));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (frame_err === 1'b1) n_ferr++;
    if (par_valid === 1'b1) begin
      n_vcyc++;
      last_word = par_out;
    end
  end

  task automatic step(logic v, logic s, logic b, logic d,
                      logic r, logic rst);
    @(negedge clk);
    #1;
    ser_valid = v;
    ser_start = s;
    ser_in    = b;
    ser_dir   = d;
    par_ready = r;
    reset     = rst;
  endtask

  task automatic idle(logic r);
    step(1'b0, 1'b0, 1'b0, 1'b0, r, 1'b0);
  endtask

  task automatic word(logic [W-1:0] bits, logic d, logic r);
    for (int i = 0; i < W; i++) begin
      step(1'b1, (i == 0), bits[W-1-i], d, r, 1'b0);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
  endtask

  initial begin
    do_reset();
    check("rst_valid", 32'(par_valid), 32'd0);
    check("rst_out", 32'(par_out), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);

    // MSB-first 1,0,1,1
    word(4'b1011, 1'b0, 1'b0);
    idle(1'b0);
    check("msb_valid", 32'(par_valid), 32'd1);
    check("msb_out", 32'(par_out), 32'hB);
    idle(1'b1);
    idle(1'b0);
    check("msb_consumed", 32'(par_valid), 32'd0);

    // LSB-first 1,0,1,1 with gaps
    n_vcyc = 0;
    for (int i = 0; i < W; i++) begin
      step(1'b1, (i == 0), (i != 1), 1'b1, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
    end
    idle(1'b1);
    idle(1'b1);
    check("lsb_once", 32'(n_vcyc), 32'd1);
    check("lsb_out", 32'(last_word), 32'hD);

    // restart mid-word
    n_ferr = 0;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    word(4'b0110, 1'b0, 1'b0);
    idle(1'b0);
    check("restart_ferr", 32'(n_ferr), 32'd1);
    check("restart_valid", 32'(par_valid), 32'd1);
    check("restart_out", 32'(par_out), 32'h6);
    idle(1'b1);

    // overrun
    idle(1'b0);
    word(4'b1001, 1'b0, 1'b0);
    word(4'b0111, 1'b0, 1'b0);
    idle(1'b0);
    check("ovr_out", 32'(par_out), 32'h9);
    check("ovr_flag", 32'(overrun), 32'd1);
    idle(1'b1);
    idle(1'b0);
    check("ovr_drain", 32'(par_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // complete and consume in the same cycle
    do_reset();
    word(4'b0011, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    check("swap_valid", 32'(par_valid), 32'd1);
    check("swap_out", 32'(par_out), 32'hC);
    check("swap_ovr", 32'(overrun), 32'd0);

    // reset mid-word, reset also beating a completing bit
    do_reset();
    n_ferr = 0;
    n_vcyc = 0;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    word(4'b1111, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("rstmid_words", 32'(n_vcyc), 32'd1);
    check("rstmid_out", 32'(last_word), 32'hF);
    check("rstmid_ferr", 32'(n_ferr), 32'd0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
